// File: rtl/dice_img_pkg.sv
// Shared image constants, FSM state encoding and bank encoding for the DIC image path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dice_img_pkg;

    localparam int IMG_W_DEFAULT = 232;
    localparam int IMG_H_DEFAULT = 448;
    localparam int FRAME_PIXELS  = IMG_W_DEFAULT * IMG_H_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bank encoding is shared with the downstream ref/def swap mux.
    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_t;

endpackage

// File: rtl/pix_addr_counter.sv
// Loadable pixel address counter: load-to-1 on SOF, increment per word, clear at frame end.
// Latency: count updates on the edge after the control strobe; terminal flag is combinational.
// Backpressure: none, the caller only strobes i_inc on accepted words.
module pix_addr_counter #(
    parameter int ADDR_W = 17,
    parameter int COUNT  = 232 * 448
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load1,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COUNT - 1);

    logic [ADDR_W-1:0] r_cnt;

    // Clear wins over load, load wins over increment (a SOF word restarts at 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= ADDR_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    // High while the next word to be written is the last pixel of the frame.
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/frame_pingpong_writer.sv
// Writes the pixel stream into alternating frame banks (odd frames A, even frames B) and counts frames.
// Latency: write strobe one cycle after the accepting edge; frame_done the cycle after the last strobe.
// Backpressure: pix_ready drops for the single DONE cycle that ends each frame, otherwise always ready.
module frame_pingpong_writer
    import dice_img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [31:0]       frame_counter,
    output logic              frame_done,
    output logic              sof_err,
    output logic              busy
);

    localparam int N = IMG_W * IMG_H;

    state_t            r_state;
    state_t            w_state_nxt;
    bank_t             r_bank;
    logic              r_pix_ready;
    logic              r_wr_en_a;
    logic              r_wr_en_b;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [31:0]       r_frame_counter;
    logic              r_frame_done;
    logic              r_sof_err;
    logic              r_busy;

    logic              w_accept;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_sof_err_nxt;
    logic              w_done_nxt;
    logic              w_load1;
    logic              w_inc;
    logic              w_clr;
    logic [ADDR_W-1:0] w_cnt;
    logic              w_tc;

    assign w_accept = pix_valid && r_pix_ready;

    pix_addr_counter #(
        .ADDR_W (ADDR_W),
        .COUNT  (N)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the write port and pulses.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr          = 1'b0;
        w_addr_nxt    = r_wr_addr;
        w_data_nxt    = r_wr_data;
        w_sof_err_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_load1       = 1'b0;
        w_inc         = 1'b0;
        w_clr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Words before a SOF are dropped silently.
                if (w_accept && pix_sof) begin
                    w_wr        = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = pix_data;
                    w_load1     = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_accept) begin
                    w_wr       = 1'b1;
                    w_data_nxt = pix_data;
                    if (pix_sof) begin
                        // Abort and restart the same bank; frame count is untouched.
                        w_addr_nxt    = '0;
                        w_load1       = 1'b1;
                        w_sof_err_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = w_cnt;
                        w_inc      = 1'b1;
                        if (w_tc) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_clr       = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, bank select and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank          <= BANK_A;
            r_pix_ready     <= 1'b0;
            r_wr_en_a       <= 1'b0;
            r_wr_en_b       <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_frame_counter <= '0;
            r_frame_done    <= 1'b0;
            r_sof_err       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_pix_ready  <= (w_state_nxt != ST_DONE);
            r_busy       <= (w_state_nxt == ST_WRITE);
            r_wr_en_a    <= w_wr && (r_bank == BANK_A);
            r_wr_en_b    <= w_wr && (r_bank == BANK_B);
            r_wr_addr    <= w_addr_nxt;
            r_wr_data    <= w_data_nxt;
            r_frame_done <= w_done_nxt;
            r_sof_err    <= w_sof_err_nxt;
            if (r_state == ST_DONE) begin
                r_frame_counter <= r_frame_counter + 32'd1;
                r_bank          <= (r_bank == BANK_A) ? BANK_B : BANK_A;
            end
        end
    end

    assign pix_ready     = r_pix_ready;
    assign wr_en_a       = r_wr_en_a;
    assign wr_en_b       = r_wr_en_b;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign frame_counter = r_frame_counter;
    assign frame_done    = r_frame_done;
    assign sof_err       = r_sof_err;
    assign busy          = r_busy;

endmodule

// File: tb/tb_frame_pingpong_writer.sv
// Bench for frame_pingpong_writer with a 4x2 frame: directed scenarios plus a random stream.
// Expected writes come from a frame-level model (frame parity picks the bank, word index is the address).
// Observed strobes are collected at the falling edge and compared after each scenario.
module tb_frame_pingpong_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          wr_en_a;
    logic          wr_en_b;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [31:0]   frame_counter;
    logic          frame_done;
    logic          sof_err;
    logic          busy;

    frame_pingpong_writer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .wr_en_a       (wr_en_a),
        .wr_en_b       (wr_en_b),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_counter (frame_counter),
        .frame_done    (frame_done),
        .sof_err       (sof_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: frames completed since reset, position within the open frame.
    wr_t         exp_q[$];
    logic [31:0] exp_fc_q[$];
    int          m_frames = 0;
    bit          m_in_frame = 1'b0;
    int          m_cnt = 0;
    int          m_sof_err = 0;

    // Observations collected from the DUT.
    wr_t         obs_q[$];
    logic [31:0] obs_fc_q[$];
    int          o_done = 0;
    int          o_sof_err = 0;
    int          o_both = 0;
    int          o_ready_low = 0;
    int          o_misalign = 0;
    bit          prev_last = 1'b0;

    always @(negedge clk) begin
        if (wr_en_a && wr_en_b) o_both++;
        if (wr_en_a || wr_en_b) obs_q.push_back({wr_en_b, wr_addr, wr_data});
        if (frame_done) begin
            o_done++;
            obs_fc_q.push_back(frame_counter);
            if (!prev_last) o_misalign++;
        end
        if (sof_err) o_sof_err++;
        if (!rst && !pix_ready) o_ready_low++;
        prev_last = (wr_en_a || wr_en_b) && (wr_addr == AW'(N - 1));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_bank();
        return m_frames[0];
    endfunction

    task automatic model_accept(input logic sof, input logic [DW-1:0] d);
        if (sof) begin
            if (m_in_frame) m_sof_err++;
            exp_q.push_back({m_bank(), AW'(0), d});
            m_cnt      = 1;
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            exp_q.push_back({m_bank(), AW'(m_cnt), d});
            m_cnt++;
        end
        if (m_in_frame && m_cnt == N) begin
            m_in_frame = 1'b0;
            m_frames++;
            exp_fc_q.push_back(32'(m_frames));
        end
    endtask

    // Present one word (or an idle cycle) and hold it until the DUT takes it.
    task automatic send(input logic v, input logic s, input logic [DW-1:0] d);
        logic rdy;
        bit   taken;
        taken     = 1'b0;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        for (int t = 0; t < 20 && !taken; t++) begin
            @(negedge clk);
            rdy = pix_ready;
            @(posedge clk);
            #1;
            if (!v) begin
                taken = 1'b1;
            end else if (rdy) begin
                model_accept(s, d);
                taken = 1'b1;
            end
        end
        if (!taken) chk("handshake_timeout", 64'd0, 64'd1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < N; i++) begin
            send(1'b1, (i == 0), rnd ? DW'($urandom) : base + DW'(i));
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctl"}, {wr_en_a, wr_en_b, frame_done, sof_err, busy, pix_ready, wr_addr}, 64'd0);
        chk({tag, "_data"}, wr_data, 64'd0);
        chk({tag, "_fc"}, frame_counter, 64'd0);
    endtask

    task automatic apply_reset();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_fc_q.delete();
        obs_q.delete();
        obs_fc_q.delete();
        m_frames    = 0;
        m_in_frame  = 1'b0;
        m_cnt       = 0;
        m_sof_err   = 0;
        o_done      = 0;
        o_sof_err   = 0;
        o_both      = 0;
        o_ready_low = 0;
        o_misalign  = 0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", pix_ready, 64'd1);
    endtask

    task automatic end_test(input string tag);
        int n;
        pix_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_write%0d", tag, i), obs_q[i], exp_q[i]);
        end
        chk({tag, "_ndone"}, o_done, exp_fc_q.size());
        n = (obs_fc_q.size() < exp_fc_q.size()) ? obs_fc_q.size() : exp_fc_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_fc_at_done%0d", tag, i), obs_fc_q[i], exp_fc_q[i]);
        end
        chk({tag, "_sof_err"}, o_sof_err, m_sof_err);
        chk({tag, "_both_banks"}, o_both, 64'd0);
        chk({tag, "_ready_low"}, o_ready_low, m_frames);
        chk({tag, "_done_align"}, o_misalign, 64'd0);
        chk({tag, "_fc"}, frame_counter, 32'(m_frames));
        chk({tag, "_busy"}, busy, m_in_frame);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        apply_reset();

        // Single frame, data 0x10..0x17, bank A.
        send_frame(32'h10, 1'b0);
        end_test("single");

        // Three frames back to back: banks A, B, A and counter 1, 2, 3.
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(32'h100 * (f + 1), 1'b1);
        end_test("three");

        // Valid every other cycle.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            send(1'b1, (i == 0), DW'($urandom));
            send(1'b0, 1'b0, DW'($urandom));
        end
        end_test("gapped");

        // SOF after 5 words restarts the same bank at address 0.
        apply_reset();
        for (int i = 0; i < 5; i++) send(1'b1, (i == 0), DW'($urandom));
        send(1'b1, 1'b1, 32'hAA);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, DW'($urandom));
        end_test("mid_sof");

        // Garbage before the first SOF.
        apply_reset();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, DW'($urandom));
        send_frame(32'h0, 1'b1);
        end_test("garbage");

        // Reset during the second frame.
        apply_reset();
        send_frame(32'h0, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, (i == 0), DW'($urandom));
        rst = 1'b1;
        #1;
        chk_reset_values("async_reset");
        apply_reset();
        send_frame(32'h0, 1'b1);
        end_test("after_reset");

        // Random stream with random gaps and SOFs.
        apply_reset();
        send_frame(32'h0, 1'b1);
        for (int i = 0; i < 120; i++) begin
            send(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), DW'($urandom));
        end
        end_test("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_pingpong_writer.md
# frame_pingpong_writer

Captures the incoming 32-bit pixel stream into two alternating frame buffers (bank A / bank B). It maintains the `frame_counter` that downstream ref/def swap logic uses to pick which bank is the reference image and which is the deformed image. It sits between the camera/DMA input and the dual image buffers, ahead of the correlation datapath. Frame n (1-based) is always written to bank A when n is odd and bank B when n is even.

## Interface
- `IMG_W`, default 232: pixels per line.
- `IMG_H`, default 448: lines per frame.
- `DATA_W`, default 32: pixel word width.
- `ADDR_W`, default 17: buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pix_valid`  in  1  input word valid.
- `pix_sof`  in  1  start of frame; qualified by `pix_valid`, marks the first pixel.
- `pix_data`  in  DATA_W  pixel word.
- `pix_ready`  out  1  writer accepts a word when `pix_valid && pix_ready`.
- `wr_en_a`  out  1  write strobe, bank A.
- `wr_en_b`  out  1  write strobe, bank B.
- `wr_addr`  out  ADDR_W  write address, shared by both banks.
- `wr_data`  out  DATA_W  write data, shared by both banks.
- `frame_counter`  out  32  number of completed frames since reset.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `sof_err`  out  1  one-cycle pulse when an unexpected SOF arrives mid-frame.
- `busy`  out  1  high while in WRITE.

## Operation
- States:
  - IDLE: waiting for SOF. Accepted words without `pix_sof` are discarded, with no write and no error.
  - WRITE: capturing a frame.
  - DONE: one-cycle finalisation.
- IDLE -> WRITE on an accepted word with `pix_sof`=1. That word is written at address 0, `pix_cnt` becomes 1, and the bank is selected by `bank_sel`.
- WRITE: each accepted word is written at address `pix_cnt`, then `pix_cnt` increments. When the word at address IMG_W*IMG_H-1 is accepted, the FSM moves to DONE.
- Accepted word with `pix_sof`=1 while in WRITE:
  - pulse `sof_err`;
  - restart the same bank: that word is written at address 0 and `pix_cnt` becomes 1;
  - `frame_counter` does not change.
- DONE: `frame_counter` += 1 (32-bit wrap, 0xFFFFFFFF -> 0), `bank_sel` toggles, `frame_done` = 1, then go to IDLE.
- `bank_sel` resets to A and toggles only in DONE, so bank parity always equals frame parity.
- `pix_ready` = 1 in IDLE and WRITE, and 0 in DONE and during reset.
- An aborted frame (SOF restart) never increments the counter or toggles the bank.

## Timing
- All outputs are registered.
- Write latency: the strobe appears one cycle after the accepting edge.
  - `wr_en_a`/`wr_en_b` are asserted for exactly one cycle per accepted in-frame word.
  - Never both high at once.
  - `wr_addr`/`wr_data` are valid during the strobe.
- `frame_done` and the updated `frame_counter` appear on the same cycle. That cycle directly follows the last-word write strobe.
- A back-to-back SOF is accepted no earlier than the cycle after DONE. A frame occupies N+1 cycles minimum, where N = IMG_W*IMG_H.
- Reset values:
  - `frame_counter`=0, `bank_sel`=A, state=IDLE, `pix_cnt`=0.
  - All strobes/pulses are 0; `wr_addr`=0, `wr_data`=0.
  - `pix_ready`=0 while `rst` is high, and 1 from the first edge after deassertion.
- Reset mid-frame: the partial frame is abandoned. No `frame_done` is pulsed and `frame_counter` returns to 0.

## Structure
- Shared package `dice_img_pkg`:
  - IMG_W/IMG_H defaults;
  - the FRAME_PIXELS constant;
  - the state enum (IDLE/WRITE/DONE);
  - the bank encoding (A=0, B=1), which the swap mux also uses.
- One natural sub-module: `pix_addr_counter`. It is a loadable address counter with terminal-count flag, load-to-1 on SOF, and clear on DONE.
- FSM and bank/frame registers stay in the top level.

## Test plan
Tests use IMG_W=4, IMG_H=2 (N=8).
- **Single frame:** reset, SOF + 8 consecutive valid words 0x10..0x17.
  - `wr_en_a` pulses at addresses 0..7 with matching data, and `wr_en_b` stays 0.
  - `frame_done` = 1 for one cycle, `frame_counter`=1.
- **Three frames back-to-back.**
  - Banks go A, B, A.
  - `frame_counter` steps 1, 2, 3.
  - `pix_ready` drops for exactly one cycle per frame.
- **Gapped valid:** `pix_valid` toggles every other cycle.
  - Addresses are still contiguous 0..7 with no duplicate writes.
  - The frame completes after 8 accepted words.
- **Mid-frame SOF:** after 5 words, assert SOF with data 0xAA.
  - `sof_err` pulses once, 0xAA is written at address 0 of the same bank, and the counter is unchanged.
  - After 7 more words: `frame_done`, counter=1, bank A.
- **Pre-SOF garbage:** 3 valid words without SOF, then a normal frame.
  - There are no strobes for the garbage words.
  - The frame is written to bank A at 0..7.
- **Reset mid-frame:** assert `rst` after 4 words of frame 2.
  - Outputs clear immediately (asynchronous).
  - The next frame goes to bank A, and the counter ends at 1.
